seq_adder_64bit: RTL and testbench



---
 rtl/alu_pkg.sv | 12 +
 rtl/chunk_adder.sv | 12 +
 rtl/seq_adder_64bit.sv | 122 ++++++++++++
 tb/tb_seq_adder_64bit.sv | 216 +++++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// Shared ALU types: datapath width, word type and the sequential adder state encoding.
package alu_pkg;
  localparam int XLEN = 64;

  typedef logic [XLEN-1:0] word_t;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } seq_add_state_t;
endpackage

// File: rtl/chunk_adder.sv
// Combinational W-bit ripple add with carry in and carry out.
module chunk_adder #(
  parameter int W = 16
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic         cin,
  output logic [W-1:0] sum,
  output logic         cout
);
  assign {cout, sum} = {1'b0, a} + {1'b0, b} + {{W{1'b0}}, cin};
endmodule

// File: rtl/seq_adder_64bit.sv
// Multi-cycle 64-bit signed adder, CHUNK_W bits per cycle with a registered carry.
// Optional SEQ_ADDER_SUB_EN adds a 'sub' input that turns the operation into A - B.
module seq_adder_64bit
  import alu_pkg::*;
#(
  parameter int CHUNK_W = 16
) (
  input  logic  clk,
  input  logic  rst,
  input  logic  in_valid,
  output logic  in_ready,
  input  word_t a,
  input  word_t b,
  input  logic  cin,
`ifdef SEQ_ADDER_SUB_EN
  input  logic  sub,
`endif
  output logic  out_valid,
  input  logic  out_ready,
  output word_t sum,
  output logic  cout,
  output logic  overflow
);
  localparam int NUM_CHUNKS = XLEN / CHUNK_W;
  localparam int CNT_W      = (NUM_CHUNKS > 1) ? $clog2(NUM_CHUNKS) : 1;
  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(NUM_CHUNKS - 1);

  seq_add_state_t state;
  word_t          a_reg;
  word_t          b_reg;
  word_t          sum_reg;
  logic           carry;
  logic [CNT_W-1:0] idx;
  logic           cout_reg;
  logic           ovf_reg;
  logic           in_ready_reg;
  logic           out_valid_reg;

  logic [CHUNK_W-1:0] a_chunk;
  logic [CHUNK_W-1:0] b_chunk;
  logic [CHUNK_W-1:0] chunk_sum;
  logic               chunk_cout;

  logic op_sub;
`ifdef SEQ_ADDER_SUB_EN
  assign op_sub = sub;
`else
  assign op_sub = 1'b0;
`endif

  assign a_chunk = a_reg[idx*CHUNK_W +: CHUNK_W];
  assign b_chunk = b_reg[idx*CHUNK_W +: CHUNK_W];

  chunk_adder #(.W(CHUNK_W)) u_chunk_adder (
    .a    (a_chunk),
    .b    (b_chunk),
    .cin  (carry),
    .sum  (chunk_sum),
    .cout (chunk_cout)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state         <= IDLE;
      a_reg         <= '0;
      b_reg         <= '0;
      sum_reg       <= '0;
      carry         <= 1'b0;
      idx           <= '0;
      cout_reg      <= 1'b0;
      ovf_reg       <= 1'b0;
      in_ready_reg  <= 1'b1;
      out_valid_reg <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            a_reg        <= a;
            b_reg        <= op_sub ? ~b : b;
            carry        <= op_sub ? 1'b1 : cin;
            idx          <= '0;
            in_ready_reg <= 1'b0;
            state        <= RUN;
          end
        end
        RUN: begin
          sum_reg[idx*CHUNK_W +: CHUNK_W] <= chunk_sum;
          carry <= chunk_cout;
          if (idx == LAST_IDX) begin
            idx           <= '0;
            cout_reg      <= chunk_cout;
            // b_reg holds ~B for subtraction, so one sign test covers both modes
            ovf_reg       <= (a_reg[XLEN-1] == b_reg[XLEN-1]) &&
                             (chunk_sum[CHUNK_W-1] != a_reg[XLEN-1]);
            out_valid_reg <= 1'b1;
            state         <= DONE;
          end else begin
            idx <= idx + CNT_W'(1);
          end
        end
        DONE: begin
          if (out_ready) begin
            out_valid_reg <= 1'b0;
            in_ready_reg  <= 1'b1;
            state         <= IDLE;
          end
        end
        default: begin
          out_valid_reg <= 1'b0;
          in_ready_reg  <= 1'b1;
          state         <= IDLE;
        end
      endcase
    end
  end

  assign in_ready  = in_ready_reg;
  assign out_valid = out_valid_reg;
  assign sum       = sum_reg;
  assign cout      = cout_reg;
  assign overflow  = ovf_reg;
endmodule

// File: tb/tb_seq_adder_64bit.sv
// Self-checking bench for seq_adder_64bit: vector table, scoreboard queue and corner sequences.
module tb_seq_adder_64bit;
  import alu_pkg::*;

  localparam int CHUNK_W    = 16;
  localparam int NUM_CHUNKS = XLEN / CHUNK_W;
  localparam int NVEC       = 12;

  logic  clk = 1'b0;
  logic  rst;
  logic  in_valid;
  logic  in_ready;
  word_t a;
  word_t b;
  logic  cin;
  logic  sub;
  logic  out_valid;
  logic  out_ready;
  word_t sum;
  logic  cout;
  logic  overflow;

  int checks   = 0;
  int failures = 0;

  typedef struct {
    word_t a;
    word_t b;
    logic  cin;
    logic  sub;
    word_t sum;
    logic  cout;
    logic  ovf;
  } vec_t;

  typedef struct {
    word_t sum;
    logic  cout;
    logic  ovf;
  } exp_t;

  vec_t vecs[NVEC];
  exp_t sb[$];

  always #5 clk = ~clk;

  seq_adder_64bit #(.CHUNK_W(CHUNK_W)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .cin       (cin),
`ifdef SEQ_ADDER_SUB_EN
    .sub       (sub),
`endif
    .out_valid (out_valid),
    .out_ready (out_ready),
    .sum       (sum),
    .cout      (cout),
    .overflow  (overflow)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  function automatic vec_t mk(input word_t va, input word_t vb, input logic vc);
    vec_t v;
    logic [64:0] t;
    t      = {1'b0, va} + {1'b0, vb} + {64'd0, vc};
    v.a    = va;
    v.b    = vb;
    v.cin  = vc;
    v.sub  = 1'b0;
    v.sum  = t[63:0];
    v.cout = t[64];
    v.ovf  = (va[63] == vb[63]) && (t[63] != va[63]);
    return v;
  endfunction

  // hold = 0: out_ready high throughout; otherwise out_ready low for hold cycles of DONE
  task automatic run_op(input vec_t v, input int hold);
    exp_t e;
    int   cnt;
    @(negedge clk);
    a         = v.a;
    b         = v.b;
    cin       = v.cin;
    sub       = v.sub;
    in_valid  = 1'b1;
    out_ready = (hold == 0);
    check("in_ready_idle", {63'd0, in_ready}, 64'd1);
    sb.push_back('{v.sum, v.cout, v.ovf});
    @(posedge clk); #1;
    check("in_ready_busy", {63'd0, in_ready}, 64'd0);
    @(negedge clk);
    in_valid = 1'b0;
    a        = {$urandom, $urandom};
    b        = {$urandom, $urandom};
    cin      = ~v.cin;
    sub      = ~v.sub;
    cnt      = 0;
    do begin
      @(posedge clk); #1;
      cnt++;
    end while (!out_valid && cnt < 20);
    check("latency", 64'(cnt), 64'(NUM_CHUNKS));
    if (!out_valid) return;
    if (sb.size() == 0) begin
      check("sb_empty", 64'd0, 64'd1);
      return;
    end
    e = sb.pop_front();
    check("sum", sum, e.sum);
    check("cout", {63'd0, cout}, {63'd0, e.cout});
    check("overflow", {63'd0, overflow}, {63'd0, e.ovf});
    check("in_ready_done", {63'd0, in_ready}, 64'd0);
    if (hold > 0) begin
      repeat (hold) begin
        @(posedge clk); #1;
        check("bp_valid", {63'd0, out_valid}, 64'd1);
        check("bp_sum", sum, e.sum);
        check("bp_in_ready", {63'd0, in_ready}, 64'd0);
      end
      @(negedge clk);
      out_ready = 1'b1;
    end
    @(posedge clk); #1;
    check("valid_drop", {63'd0, out_valid}, 64'd0);
    check("in_ready_back", {63'd0, in_ready}, 64'd1);
    @(negedge clk);
    out_ready = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t v;
    vecs[0]  = '{64'd5, 64'd7, 1'b0, 1'b0, 64'd12, 1'b0, 1'b0};
    vecs[1]  = '{64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 1'b0, 1'b0, 64'd0, 1'b1, 1'b0};
    vecs[2]  = '{64'h7FFF_FFFF_FFFF_FFFF, 64'd1, 1'b0, 1'b0, 64'h8000_0000_0000_0000, 1'b0, 1'b1};
    vecs[3]  = '{64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 1'b1, 1'b0,
                 64'hFFFF_FFFF_FFFF_FFFF, 1'b1, 1'b0};
    vecs[4]  = '{64'h8000_0000_0000_0000, 64'h8000_0000_0000_0000, 1'b0, 1'b0, 64'd0, 1'b1, 1'b1};
    vecs[5]  = '{64'd0, 64'd0, 1'b1, 1'b0, 64'd1, 1'b0, 1'b0};
    vecs[6]  = '{64'h0000_0000_0000_FFFF, 64'd1, 1'b0, 1'b0, 64'h0000_0000_0001_0000, 1'b0, 1'b0};
    for (int i = 7; i < NVEC; i++)
      vecs[i] = mk({$urandom, $urandom}, {$urandom, $urandom}, 1'(i));

    rst       = 1'b1;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    a         = '0;
    b         = '0;
    cin       = 1'b0;
    sub       = 1'b0;
    #12;
    check("rst_in_ready", {63'd0, in_ready}, 64'd1);
    check("rst_out_valid", {63'd0, out_valid}, 64'd0);
    check("rst_sum", sum, 64'd0);
    check("rst_cout", {63'd0, cout}, 64'd0);
    check("rst_overflow", {63'd0, overflow}, 64'd0);
    @(negedge clk);
    rst = 1'b0;

    for (int i = 0; i < NVEC; i++)
      run_op(vecs[i], (i % 3 == 0) ? 0 : 2);

    // backpressure: result held for 10 cycles
    run_op(vecs[2], 10);

    // reset two cycles into RUN discards the operation
    @(negedge clk);
    a        = 64'd100;
    b        = 64'd200;
    cin      = 1'b0;
    in_valid = 1'b1;
    @(posedge clk); #1;
    @(negedge clk);
    in_valid = 1'b0;
    @(posedge clk);
    @(posedge clk); #1;
    rst = 1'b1;
    #1;
    check("mid_rst_out_valid", {63'd0, out_valid}, 64'd0);
    check("mid_rst_in_ready", {63'd0, in_ready}, 64'd1);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk); #1;
    check("post_rst_idle_valid", {63'd0, out_valid}, 64'd0);
    run_op(mk(64'd3, 64'd4, 1'b0), 1);

`ifdef SEQ_ADDER_SUB_EN
    v = '{64'h8000_0000_0000_0000, 64'd1, 1'b1, 1'b1, 64'h7FFF_FFFF_FFFF_FFFF, 1'b1, 1'b1};
    run_op(v, 1);
    v = '{64'd5, 64'd7, 1'b1, 1'b1, 64'hFFFF_FFFF_FFFF_FFFE, 1'b0, 1'b0};
    run_op(v, 0);
    v = '{64'd7, 64'd5, 1'b0, 1'b1, 64'd2, 1'b1, 1'b0};
    run_op(v, 0);
`endif

    check("sb_drained", 64'(sb.size()), 64'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
